// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write signals of the program loader.
// master = stream source / memory side, slave = the loader itself.
interface program_loader_if;
  logic        start_i;
  logic [7:0]  byte_in_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [15:0] data_out_o;
  logic [7:0]  inst_add_o;
  logic        instruction_wenable_o;
  logic        cpu_hold_o;
  logic        load_done_o;
  logic        load_error_o;

  modport master (
    output start_i, byte_in_i, byte_valid_i,
    input  byte_ready_o, data_out_o, inst_add_o, instruction_wenable_o,
           cpu_hold_o, load_done_o, load_error_o
  );

  modport slave (
    input  start_i, byte_in_i, byte_valid_i,
    output byte_ready_o, data_out_o, inst_add_o, instruction_wenable_o,
           cpu_hold_o, load_done_o, load_error_o
  );
endinterface

// File: rtl/program_loader.sv
// Loads a count-prefixed stream of 16-bit words into instruction memory while holding the CPU.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start, CPU runs
// COUNT  | accept word count byte (0 = 256 words)
// HI     | accept high byte of next word
// LO     | accept low byte of next word
// WRITE  | one-cycle memory write strobe, advance address
// CHK    | accept checksum byte (checksum build only)
// DONE   | one-cycle completion pulse
module program_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input logic             clk,
  input logic             rst,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ST_CHK   = 3'd5,
`endif
    ST_DONE  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  remaining_q, remaining_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        ready_c, wen_c, hold_c, done_c;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  logic        err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      addr_q      <= BASE_ADDR;
      data_q      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ready_c     = 1'b0;
    wen_c       = 1'b0;
    hold_c      = 1'b1;
    done_c      = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        hold_c = 1'b0;
        if (bus.start_i) begin
          state_d = ST_COUNT;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_COUNT: begin
        ready_c = 1'b1;
        if (bus.byte_valid_i) begin
          // A zero count byte encodes a full 256-word image.
          remaining_d = (bus.byte_in_i == 8'h00) ? 9'd256 : {1'b0, bus.byte_in_i};
          addr_d      = BASE_ADDR;
          state_d     = ST_HI;
        end
      end
      ST_HI: begin
        ready_c = 1'b1;
        if (bus.byte_valid_i) begin
          data_d[15:8] = bus.byte_in_i;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d       = csum_q ^ bus.byte_in_i;
`endif
          state_d      = ST_LO;
        end
      end
      ST_LO: begin
        ready_c = 1'b1;
        if (bus.byte_valid_i) begin
          data_d[7:0] = bus.byte_in_i;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ bus.byte_in_i;
`endif
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wen_c       = 1'b1;
        addr_d      = addr_q + 8'd1;
        remaining_d = remaining_q - 9'd1;
        if (remaining_q == 9'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_HI;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        ready_c = 1'b1;
        if (bus.byte_valid_i) begin
          if (bus.byte_in_i != csum_q) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        hold_c  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.byte_ready_o          = ready_c;
  assign bus.instruction_wenable_o = wen_c;
  assign bus.cpu_hold_o            = hold_c;
  assign bus.load_done_o           = done_c;
  assign bus.data_out_o            = data_q;
  assign bus.inst_add_o            = addr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign bus.load_error_o          = err_q;
`else
  assign bus.load_error_o          = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: two loaders (base 00 and FF) share one randomized byte stream,
// and every captured write is compared with the expected image placement.
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, byte_valid;
  logic [7:0] byte_in;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  program_loader_if ifc0 ();
  program_loader_if ifc1 ();

  assign ifc0.start_i      = start;
  assign ifc0.byte_in_i    = byte_in;
  assign ifc0.byte_valid_i = byte_valid;
  assign ifc1.start_i      = start;
  assign ifc1.byte_in_i    = byte_in;
  assign ifc1.byte_valid_i = byte_valid;

  program_loader #(.BASE_ADDR(8'h00)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
  program_loader #(.BASE_ADDR(8'hFF)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

  int checks = 0;
  int errors = 0;

  logic [23:0] wq0[$];
  logic [23:0] wq1[$];
  logic [15:0] words[$];
  int done0 = 0, done1 = 0, hold_gap = 0;
  bit in_load = 1'b0;

  always @(negedge clk) begin
    if (ifc0.instruction_wenable_o) wq0.push_back({ifc0.inst_add_o, ifc0.data_out_o});
    if (ifc1.instruction_wenable_o) wq1.push_back({ifc1.inst_add_o, ifc1.data_out_o});
    if (ifc0.load_done_o) begin
      done0++;
      if (!ifc0.cpu_hold_o) hold_gap++;
    end
    if (ifc1.load_done_o) done1++;
    if (in_load && (!ifc0.cpu_hold_o || !ifc1.cpu_hold_o)) hold_gap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, need completion)");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ifc0.byte_ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_byte: byte_ready got 0 for 100 cycles, need 1 (byte %h)", b);
    end
  endtask

  // Drives one complete load from the words queue and checks placement, pulses and flags.
  task automatic run_load(input string name, input int n, input int gap_max,
                          input int stall_word, input int stall_len,
                          input bit bad_csum, input bit poke_start);
    logic [7:0] cs = 8'h00;
    int base_sz;
    bit ok = 1'b0;
    logic [23:0] exp0, exp1;
    wq0.delete();
    wq1.delete();
    done0 = 0;
    done1 = 0;
    hold_gap = 0;
    pulse_start();
    in_load = 1'b1;
    send_byte(n[7:0]);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, gap_max));
      send_byte(words[i][15:8]);
      if (i == stall_word) begin
        base_sz = wq0.size();
        for (int k = 0; k < stall_len; k++) begin
          if (poke_start && k == 1) start = 1'b1;
          @(negedge clk);
          checks++;
          if (ifc0.byte_ready_o !== 1'b1 || wq0.size() != base_sz) begin
            errors++;
            $display("FAIL %s stall_hold: ready=%b writes=%0d, need ready=1 writes=%0d",
                     name, ifc0.byte_ready_o, wq0.size(), base_sz);
          end
          @(posedge clk);
          #1;
          start = 1'b0;
        end
      end else begin
        idle($urandom_range(0, gap_max));
      end
      send_byte(words[i][7:0]);
      cs = cs ^ words[i][15:8] ^ words[i][7:0];
    end
    if (CSUM) send_byte(bad_csum ? (cs ^ 8'h01) : cs);
    for (int t = 0; t < 1000; t++) begin
      @(posedge clk);
      if (done0 > 0) begin
        ok = 1'b1;
        break;
      end
    end
    in_load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s done_wait: load_done got none, need one pulse", name);
    end
    checks++;
    if (done0 != 1 || done1 != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d/%0d, need 1/1", name, done0, done1);
    end
    checks++;
    if (hold_gap != 0) begin
      errors++;
      $display("FAIL %s cpu_hold: got %0d low cycles during load, need 0", name, hold_gap);
    end
    checks++;
    if (ifc0.cpu_hold_o !== 1'b0 || ifc1.cpu_hold_o !== 1'b0) begin
      errors++;
      $display("FAIL %s hold_after: got %b/%b, need 0/0", name, ifc0.cpu_hold_o, ifc1.cpu_hold_o);
    end
    checks++;
    if (wq0.size() != n || wq1.size() != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d/%0d, need %0d", name, wq0.size(), wq1.size(), n);
    end
    for (int i = 0; i < n && i < wq0.size() && i < wq1.size(); i++) begin
      exp0 = {8'(i), words[i]};
      exp1 = {8'(255 + i), words[i]};
      checks++;
      if (wq0[i] !== exp0 || wq1[i] !== exp1) begin
        errors++;
        $display("FAIL %s write[%0d]: got %h/%h, need %h/%h", name, i, wq0[i], wq1[i], exp0, exp1);
      end
    end
    checks++;
    if (ifc0.data_out_o !== words[n-1] || ifc0.inst_add_o !== 8'(n) ||
        ifc1.inst_add_o !== 8'(255 + n)) begin
      errors++;
      $display("FAIL %s hold_values: got data %h addr %h/%h, need data %h addr %h/%h", name,
               ifc0.data_out_o, ifc0.inst_add_o, ifc1.inst_add_o, words[n-1], 8'(n), 8'(255 + n));
    end
    checks++;
    if (ifc0.load_error_o !== (CSUM && bad_csum)) begin
      errors++;
      $display("FAIL %s load_error: got %b, need %b", name, ifc0.load_error_o, CSUM && bad_csum);
    end
    idle(1);
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    checks++;
    if (ifc0.byte_ready_o !== 1'b0 || ifc0.instruction_wenable_o !== 1'b0 ||
        ifc0.cpu_hold_o !== 1'b0 || ifc0.load_done_o !== 1'b0 || ifc0.load_error_o !== 1'b0 ||
        ifc0.data_out_o !== 16'h0000 || ifc0.inst_add_o !== 8'h00 ||
        ifc1.cpu_hold_o !== 1'b0 || ifc1.data_out_o !== 16'h0000 || ifc1.inst_add_o !== 8'hFF) begin
      errors++;
      $display("FAIL %s: got rdy%b we%b hold%b done%b err%b d%h a%h/%h, need 0 0 0 0 0 0000 00/ff",
               name, ifc0.byte_ready_o, ifc0.instruction_wenable_o, ifc0.cpu_hold_o,
               ifc0.load_done_o, ifc0.load_error_o, ifc0.data_out_o, ifc0.inst_add_o,
               ifc1.inst_add_o);
    end
  endtask

  task automatic test_reset();
    check_reset_outputs("reset_state");
    rst = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    idle(4);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc0.cpu_hold_o !== 1'b0 || ifc0.byte_ready_o !== 1'b0 || wq0.size() != 0) begin
      errors++;
      $display("FAIL idle_ignores_valid: got hold %b ready %b writes %0d, need 0 0 0",
               ifc0.cpu_hold_o, ifc0.byte_ready_o, wq0.size());
    end
    idle(1);
  endtask

  task automatic test_basic();
    words = '{16'h1234, 16'hABCD};
    run_load("basic", 2, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    words = '{16'h0102, 16'hBEEF, 16'h7777};
    run_load("stall", 3, 1, 1, 5, 1'b0, 1'b1);
  endtask

  task automatic test_checksum();
    words = '{16'h1234};
    run_load("csum_good", 1, 0, -1, 0, 1'b0, 1'b0);
    run_load("csum_bad", 1, 0, -1, 0, 1'b1, 1'b0);
    run_load("csum_cleared", 1, 1, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midload();
    wq0.delete();
    wq1.delete();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'hC3);
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    byte_valid = 1'b0;
    check_reset_outputs("reset_midload");
    rst = 1'b0;
    idle(6);
    checks++;
    if (wq0.size() != 0 || wq1.size() != 0) begin
      errors++;
      $display("FAIL reset_no_write: got %0d/%0d writes, need 0/0", wq0.size(), wq1.size());
    end
    words = '{16'h0F0F, 16'hF0F0, 16'h1357};
    run_load("reload", 3, 2, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      run_load("random", n, 2, $urandom_range(0, n - 1), $urandom_range(1, 4),
               1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  task automatic test_full_256();
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back(16'($urandom));
    run_load("full_256", 256, 0, -1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_checksum();
    test_reset_midload();
    test_random();
    test_full_256();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
